// File: rtl/regread_bypass_stage_pkg.sv
// Shared sizing for the register-read stage and the 12R/6W register file.
package regread_bypass_stage_pkg;

    localparam int RB_SRAM_DEPTH    = 128;
    localparam int RB_SRAM_INDEX    = $clog2(RB_SRAM_DEPTH);
    localparam int RB_SRAM_WIDTH    = 32;
    localparam int RB_NUM_LANES     = 6;
    localparam int RB_NUM_WB        = 6;
    localparam int RB_PAYLOAD_WIDTH = 64;
    localparam int RB_CNT_W         = 32;

    // Saturating 32-bit add for the bypass statistics counter.
    function automatic logic [RB_CNT_W-1:0] sat_add(input logic [RB_CNT_W-1:0] a,
                                                    input logic [RB_CNT_W-1:0] b);
        logic [RB_CNT_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[RB_CNT_W] ? {RB_CNT_W{1'b1}} : s[RB_CNT_W-1:0];
    endfunction

endpackage

// File: rtl/regread_bypass_stage_bypass_mux.sv
// Per-source operand select: same-cycle write data overrides register-file
// read data on a tag match; the highest-numbered matching write port wins,
// mirroring last-write-wins inside the register file.
module regread_bypass_stage_bypass_mux
    import regread_bypass_stage_pkg::*;
#(
    parameter int SRAM_INDEX = RB_SRAM_INDEX,
    parameter int SRAM_WIDTH = RB_SRAM_WIDTH,
    parameter int NUM_WB     = RB_NUM_WB
) (
    input  logic [SRAM_INDEX-1:0]        tag,
    input  logic [SRAM_WIDTH-1:0]        rd_data,
    input  logic [NUM_WB-1:0]            wb_we,
    input  logic [NUM_WB*SRAM_INDEX-1:0] wb_addr,
    input  logic [NUM_WB*SRAM_WIDTH-1:0] wb_data,
    output logic [SRAM_WIDTH-1:0]        data,
    output logic                         hit
);

    // Ascending scan so a later (higher) matching port overwrites earlier ones.
    always_comb begin
        data = rd_data;
        hit  = 1'b0;
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_we[w] && (wb_addr[w*SRAM_INDEX +: SRAM_INDEX] == tag)) begin
                data = wb_data[w*SRAM_WIDTH +: SRAM_WIDTH];
                hit  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regread_bypass_stage.sv
// Register-read stage: drives register-file read addresses, applies
// write-port bypass, and latches operands + payload into a one-deep
// output register with stall/flush and a bypass-hit counter.
module regread_bypass_stage
    import regread_bypass_stage_pkg::*;
#(
    parameter int SRAM_INDEX    = RB_SRAM_INDEX,
    parameter int SRAM_WIDTH    = RB_SRAM_WIDTH,
    parameter int NUM_LANES     = RB_NUM_LANES,
    parameter int NUM_WB        = RB_NUM_WB,
    parameter int PAYLOAD_WIDTH = RB_PAYLOAD_WIDTH
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [NUM_LANES-1:0]                 lane_valid_i,
    input  logic [2*NUM_LANES*SRAM_INDEX-1:0]    src_tag_i,
    input  logic [NUM_LANES*PAYLOAD_WIDTH-1:0]   payload_i,
    output logic [2*NUM_LANES*SRAM_INDEX-1:0]    rd_addr_o,
    input  logic [2*NUM_LANES*SRAM_WIDTH-1:0]    rd_data_i,
    input  logic [NUM_WB-1:0]                    wb_we_i,
    input  logic [NUM_WB*SRAM_INDEX-1:0]         wb_addr_i,
    input  logic [NUM_WB*SRAM_WIDTH-1:0]         wb_data_i,
    input  logic                                 stall_i,
    input  logic                                 flush_i,
    output logic                                 valid_o,
    output logic [NUM_LANES-1:0]                 lane_valid_o,
    output logic [2*NUM_LANES*SRAM_WIDTH-1:0]    opnd_o,
    output logic [NUM_LANES*PAYLOAD_WIDTH-1:0]   payload_o,
    output logic [RB_CNT_W-1:0]                  bypass_cnt_o
);

    localparam int NUM_SRC = 2 * NUM_LANES;
    localparam int HC_W    = $clog2(NUM_SRC + 1);

    logic                              valid_q;
    logic [NUM_LANES-1:0]              lane_valid_q;
    logic [NUM_SRC*SRAM_WIDTH-1:0]     opnd_q;
    logic [NUM_LANES*PAYLOAD_WIDTH-1:0] payload_q;
    logic [RB_CNT_W-1:0]               bypass_cnt_q;

    logic [NUM_SRC*SRAM_WIDTH-1:0]     sel_data;
    logic [NUM_SRC-1:0]                hit;
    logic [HC_W-1:0]                   hit_cnt;
    logic                              accept;

    // Tags go straight to the register file; data comes back the same cycle.
    assign rd_addr_o = src_tag_i;

    assign ready_o = !valid_q || !stall_i;
    assign accept  = valid_i && ready_o && !flush_i;

    for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
        regread_bypass_stage_bypass_mux #(
            .SRAM_INDEX(SRAM_INDEX),
            .SRAM_WIDTH(SRAM_WIDTH),
            .NUM_WB    (NUM_WB)
        ) u_mux (
            .tag    (src_tag_i[j*SRAM_INDEX +: SRAM_INDEX]),
            .rd_data(rd_data_i[j*SRAM_WIDTH +: SRAM_WIDTH]),
            .wb_we  (wb_we_i),
            .wb_addr(wb_addr_i),
            .wb_data(wb_data_i),
            .data   (sel_data[j*SRAM_WIDTH +: SRAM_WIDTH]),
            .hit    (hit[j])
        );
    end

    // Count bypassed sources belonging to occupied lanes only.
    always_comb begin
        hit_cnt = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (hit[j] && lane_valid_i[j/2]) hit_cnt = hit_cnt + HC_W'(1);
        end
    end

    // Output register: flush beats accept beats drain; stall holds contents frozen.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q      <= 1'b0;
            lane_valid_q <= '0;
            opnd_q       <= '0;
            payload_q    <= '0;
        end else if (flush_i) begin
            valid_q      <= 1'b0;
            lane_valid_q <= '0;
        end else if (accept) begin
            valid_q      <= 1'b1;
            lane_valid_q <= lane_valid_i;
            opnd_q       <= sel_data;
            payload_q    <= payload_i;
        end else if (!stall_i) begin
            valid_q      <= 1'b0;
        end
    end

    // Bypass statistics; survives flush, saturates rather than wrapping.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      bypass_cnt_q <= '0;
        else if (accept) bypass_cnt_q <= sat_add(bypass_cnt_q, RB_CNT_W'(hit_cnt));
    end

    assign valid_o      = valid_q;
    assign lane_valid_o = lane_valid_q;
    assign opnd_o       = opnd_q;
    assign payload_o    = payload_q;
    assign bypass_cnt_o = bypass_cnt_q;

endmodule

// File: doc/regread_bypass_stage.md
Name: regread_bypass_stage

Overview:
- Register-read pipeline stage directly upstream of the 12-read/6-write physical register file.
- Takes a 6-lane issue packet and drives the 12 read addresses (lane l: src0 on port 2l, src1 on port 2l+1).
- Takes the combinational read data back and overrides it with same-cycle write-port data (bypass) on a tag match.
- Latches operands plus payload into a one-deep output register with valid/stall handshake, flush and a bypass-hit counter.

Parameters:
- SRAM_DEPTH, 128, physical registers.
- SRAM_INDEX, 7, tag width.
- SRAM_WIDTH, 32, operand width.
- NUM_LANES, 6, issue lanes; 2 read ports per lane.
- NUM_WB, 6, register-file write ports observed for bypass.
- PAYLOAD_WIDTH, 64, opaque per-lane payload carried alongside operands.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- valid_i  in  1  upstream packet valid.
- ready_o  out  1  stage accepts the packet this cycle.
- lane_valid_i  in  NUM_LANES  per-lane occupancy.
- src_tag_i  in  2*NUM_LANES*SRAM_INDEX  source tags; lane l src k at index 2l+k.
- payload_i  in  NUM_LANES*PAYLOAD_WIDTH  per-lane payload.
- rd_addr_o  out  2*NUM_LANES*SRAM_INDEX  to register-file read addresses; combinational copy of src_tag_i.
- rd_data_i  in  2*NUM_LANES*SRAM_WIDTH  register-file read data, same ordering.
- wb_we_i  in  NUM_WB  write enables, same signals as the register-file write ports.
- wb_addr_i  in  NUM_WB*SRAM_INDEX  write addresses.
- wb_data_i  in  NUM_WB*SRAM_WIDTH  write data.
- stall_i  in  1  downstream cannot accept.
- flush_i  in  1  squash contents.
- valid_o  out  1  output register valid.
- lane_valid_o  out  NUM_LANES  latched lane occupancy.
- opnd_o  out  2*NUM_LANES*SRAM_WIDTH  latched operands.
- payload_o  out  NUM_LANES*PAYLOAD_WIDTH  latched payload.
- bypass_cnt_o  out  32  saturating count of bypassed operands.

Behaviour:
- Reset (reset=0, asynchronous): valid_o=0, lane_valid_o=0, opnd_o=0, payload_o=0, bypass_cnt_o=0. ready_o is 1 while in reset (valid_o=0).
- Handshake:
  - ready_o = !valid_o | !stall_i (combinational).
  - Accept = valid_i & ready_o & !flush_i.
- Operand select per source j:
  - If any wb_we_i[w] with wb_addr_i[w]==src_tag j, take wb_data_i of the HIGHEST matching w.
  - This matches last-write-wins in the register file.
  - Otherwise take rd_data_i j.
  - Purely combinational; one-cycle total latency from accept to valid_o.
- Register update on rising edge, in priority order:
  - flush_i=1: valid_o<=0, lane_valid_o<=0. Data registers are don't-care. Overrides accept and stall.
  - Else accept: valid_o<=1, capture lane_valid_i, selected operands, payload.
  - Else if !stall_i: valid_o<=0.
  - Else hold everything.
- Stalled contents never re-sample the register file or bypass. Operands captured at accept stay frozen.
- bypass_cnt_o:
  - On accept, add the number of bypassed sources in valid lanes (0..12); sources in invalid lanes are not counted.
  - Saturates at 32'hFFFFFFFF.
  - Not cleared by flush.
- valid_i with all lane_valid_i=0 is still accepted and produces valid_o with zero lanes.
- Tag width: bypass compares exact SRAM_INDEX bits. Tags >= SRAM_DEPTH are illegal upstream; no checking.
- Deassertion of reset is synchronised externally; the block places no constraint on it.

Decomposition:
- Shared package/include: SRAM_INDEX, SRAM_WIDTH, NUM_LANES, NUM_WB defaults and index-slicing macros for flattened vectors, shared with the register file.
- One sub-module: bypass_mux, instantiated once per source (12×). Inputs: tag, rd_data, wb_we/addr/data. Outputs: selected data and hit bit. Purely combinational, priority to highest w.

Test Plan:
- Reset: hold reset=0 with valid_i=1 → valid_o=0, bypass_cnt_o=0. Release, then accept tags 5/6 with rd_data 0xA/0xB, no writes → next cycle valid_o=1, lane0 opnd=0xA,0xB.
- Bypass priority: lane0 src0 tag 9, wb_we=6'b100001, wb_addr[0]=9 data 0x11, wb_addr[5]=9 data 0x55, rd_data 0x0 → opnd 0x55, bypass_cnt_o +1.
- Stall hold: accept packet P1, then stall_i=1 for 3 cycles with new valid_i packet P2 and writes to P1's tags → ready_o=0, P1 operands unchanged. Drop stall → P2 captured next edge.
- Flush: valid_o=1, stall_i=1, flush_i=1, valid_i=1 → next edge valid_o=0; the valid_i packet is not captured.
- Counter: 12 sources all matching write ports on lanes all valid → +12 per accept. Preload near 0xFFFFFFF8 via repeated accepts/force → saturates at 0xFFFFFFFF. Invalid lane with matching tag → not counted.
- Async reset mid-stall: assert reset=0 between edges → valid_o and bypass_cnt_o clear immediately without a clock edge.
